// File: rtl/settings_pkg.sv
// Shared types and default sizing for the settings register file.
package settings_pkg;
  localparam int WORD_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 4;
  localparam int NUM_REGS_DEF = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  // Index width that stays legal for a single-register bank.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/settings_regfile_if.sv
// Command-word handshake into the settings register file.
interface settings_regfile_if #(
  parameter int WORD_W = settings_pkg::WORD_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;

  modport master (output in_valid, in_word, input in_ready);
  modport slave  (input in_valid, in_word, output in_ready);
endinterface

// File: rtl/settings_bank.sv
// Shadow/active register pair. With SETTINGS_SHADOW_EN the shadow bank is staged
// and copied on commit; otherwise writes land in the active bank directly.
module settings_bank #(
  parameter int NUM_REGS = 8,
  parameter int FIELD_W  = 12,
  parameter int IDX_W    = 3,
  parameter logic [NUM_REGS*FIELD_W-1:0] RST_VALS = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [IDX_W-1:0]                  wr_idx,
  input  logic [FIELD_W-1:0]                wr_data,
`ifdef SETTINGS_SHADOW_EN
  input  logic                              commit,
`endif
  output logic [NUM_REGS-1:0][FIELD_W-1:0]  active
);
`ifdef SETTINGS_SHADOW_EN
  logic [NUM_REGS-1:0][FIELD_W-1:0] shadow;

  // Reset has priority so a commit in flight never leaks shadow values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RST_VALS;
      active <= RST_VALS;
    end else begin
      if (wr_en)  shadow[wr_idx] <= wr_data;
      if (commit) active <= shadow;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst)        active <= RST_VALS;
    else if (wr_en) active[wr_idx] <= wr_data;
  end
`endif
endmodule

// File: rtl/settings_regfile.sv
// Settings register file: command decode, commit FSM and registered readback.
// Optional feature macro: SETTINGS_SHADOW_EN (staged writes applied on commit).
module settings_regfile
  import settings_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter logic [NUM_REGS*(WORD_W-ADDR_W)-1:0] RST_VALS = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  settings_regfile_if.slave                     bus,
  output logic [NUM_REGS*(WORD_W-ADDR_W)-1:0]   regs_out,
  output logic                                  update,
  output logic                                  pending,
  output logic                                  bad_addr,
  input  logic [ADDR_W-1:0]                     rd_addr,
  output logic [WORD_W-ADDR_W-1:0]              rd_data
);
  localparam int FIELD_W = WORD_W - ADDR_W;
  localparam int IDX_W   = idx_w(NUM_REGS);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [ADDR_W-1:0]                addr;
  logic [FIELD_W-1:0]               payload;
  logic                             accept, in_range, wr_en, rd_ok;
  logic [NUM_REGS-1:0][FIELD_W-1:0] active;

  assign addr     = bus.in_word[WORD_W-1 -: ADDR_W];
  assign payload  = bus.in_word[FIELD_W-1:0];
  assign in_range = {1'b0, addr} < NREGS;
  assign accept   = bus.in_valid & bus.in_ready;
  assign wr_en    = accept & in_range;
  assign rd_ok    = {1'b0, rd_addr} < NREGS;
  assign regs_out = active;

`ifdef SETTINGS_SHADOW_EN
  localparam logic [ADDR_W-1:0] COMMIT_ADDR = '1;
  state_e state;
  logic   commit, is_commit;

  assign is_commit    = (addr == COMMIT_ADDR);
  assign commit       = (state == COMMIT);
  assign bus.in_ready = (state == IDLE);

  // COMMIT lasts one cycle; the copy happens on the edge leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      update   <= 1'b0;
      bad_addr <= 1'b0;
    end else begin
      state    <= (accept && is_commit) ? COMMIT : IDLE;
      update   <= commit;
      bad_addr <= accept & ~in_range & ~is_commit;
      if (commit)     pending <= 1'b0;
      else if (wr_en) pending <= 1'b1;
    end
  end
`else
  assign bus.in_ready = 1'b1;
  assign pending      = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      update   <= 1'b0;
      bad_addr <= 1'b0;
    end else begin
      update   <= wr_en;
      bad_addr <= accept & ~in_range;
    end
  end
`endif

  settings_bank #(
    .NUM_REGS (NUM_REGS),
    .FIELD_W  (FIELD_W),
    .IDX_W    (IDX_W),
    .RST_VALS (RST_VALS)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (addr[IDX_W-1:0]),
    .wr_data (payload),
`ifdef SETTINGS_SHADOW_EN
    .commit  (commit),
`endif
    .active  (active)
  );

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_ok) rd_data <= active[rd_addr[IDX_W-1:0]];
    else            rd_data <= '0;
  end
endmodule

// File: tb/tb_settings_regfile.sv
// Randomized + directed bench for settings_regfile against an array-based model.
// Model follows SETTINGS_SHADOW_EN the same way the build does.
module tb_settings_regfile;
  localparam int WORD_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 8;
  localparam int FIELD_W  = 12;
`ifdef SETTINGS_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam logic [NUM_REGS*FIELD_W-1:0] RST_VALS =
    {12'h000, 12'h000, 12'h3C3, 12'h000, 12'h000, 12'h027, 12'h000, 12'h5A5};

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_REGS*FIELD_W-1:0]  regs_out;
  logic                         update, pending, bad_addr;
  logic [ADDR_W-1:0]            rd_addr;
  logic [FIELD_W-1:0]           rd_data;

  always #5 clk = ~clk;

  settings_regfile_if #(.WORD_W(WORD_W)) bus ();

  settings_regfile #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RST_VALS(RST_VALS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .regs_out(regs_out), .update(update),
    .pending(pending), .bad_addr(bad_addr), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Reference state: plain arrays and flags
  logic [FIELD_W-1:0] m_act [NUM_REGS];
  logic [FIELD_W-1:0] m_shd [NUM_REGS];
  bit                 m_pend, m_upd, m_bad, m_cmt;
  logic [FIELD_W-1:0] m_rd;
  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [95:0] packed_act();
    logic [95:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*FIELD_W +: FIELD_W] = m_act[i];
    return v;
  endfunction

  task automatic drive(input bit v, input logic [15:0] w, input logic [3:0] ra, input bit r);
    bus.in_valid = v;
    bus.in_word  = w;
    rd_addr      = ra;
    rst          = r;
  endtask

  task automatic model_edge();
    int a;
    logic [FIELD_W-1:0] p;
    a = int'(bus.in_word[15:12]);
    p = bus.in_word[11:0];
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        m_act[i] = RST_VALS[i*FIELD_W +: FIELD_W];
        m_shd[i] = m_act[i];
      end
      m_pend = 0; m_upd = 0; m_bad = 0; m_cmt = 0; m_rd = '0;
    end else begin
      m_rd  = (int'(rd_addr) < NUM_REGS) ? m_act[rd_addr] : '0;
      m_upd = 0;
      m_bad = 0;
      if (m_cmt) begin
        for (int i = 0; i < NUM_REGS; i++) m_act[i] = m_shd[i];
        m_pend = 0; m_upd = 1; m_cmt = 0;
      end else if (bus.in_valid) begin
        if (a < NUM_REGS) begin
          if (SHADOW) begin m_shd[a] = p; m_pend = 1; end
          else begin m_act[a] = p; m_upd = 1; end
        end else if (a == 15 && SHADOW) m_cmt = 1;
        else m_bad = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("regs_out", regs_out, packed_act());
    chk("update",   update,   m_upd);
    chk("pending",  pending,  m_pend);
    chk("bad_addr", bad_addr, m_bad);
    chk("in_ready", bus.in_ready, SHADOW ? !m_cmt : 1'b1);
    chk("rd_data",  rd_data,  m_rd);
  endtask

  initial begin
    drive(0, 16'h0000, 4'd2, 1);
    step(); step();
    drive(0, 16'h0000, 4'd2, 0);
    step();
    chk("rst_reg2", regs_out[2*FIELD_W +: FIELD_W], 12'h027);
    chk("rst_rd2",  rd_data, 12'h027);
    chk("rst_pend", pending, 1'b0);

    // Two staged writes then commit
    drive(1, 16'h1ABC, 4'd1, 0); step();
    drive(1, 16'h3123, 4'd3, 0); step();
    drive(1, 16'hF000, 4'd1, 0); step();
    drive(0, 16'h0000, 4'd3, 0); step(); step();
    chk("wr_reg1", regs_out[1*FIELD_W +: FIELD_W], 12'hABC);
    chk("wr_reg3", regs_out[3*FIELD_W +: FIELD_W], 12'h123);

    // Unimplemented address
    drive(1, 16'h9555, 4'd9, 0); step();
    chk("bad_9", bad_addr, 1'b1);
    drive(0, 16'h0000, 4'd0, 0); step();

    // Word held across the commit cycle
    drive(1, 16'hF000, 4'd2, 0); step();
    drive(1, 16'h2777, 4'd2, 0); step(); step();
    drive(1, 16'hF000, 4'd2, 0); step();
    drive(0, 16'h0000, 4'd2, 0); step(); step();
    chk("held_reg2", regs_out[2*FIELD_W +: FIELD_W], 12'h777);

    // Reset landing on the commit cycle
    drive(1, 16'h0FFF, 4'd0, 0); step();
    drive(1, 16'hF000, 4'd0, 0); step();
    drive(1, 16'h0123, 4'd0, 1); step();
    drive(0, 16'h0000, 4'd0, 0); step();
`ifdef SETTINGS_SHADOW_EN
    chk("rstcmt_reg0", regs_out[FIELD_W-1:0], 12'h5A5);
`else
    chk("rstcmt_reg0", regs_out[FIELD_W-1:0], 12'h5A5);
    drive(1, 16'h0FFF, 4'd0, 0); step();
    chk("direct_reg0", regs_out[FIELD_W-1:0], 12'hFFF);
    chk("direct_upd",  update, 1'b1);
    drive(1, 16'hF000, 4'd0, 0); step();
    chk("commit_bad",  bad_addr, 1'b1);
`endif

    // Randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  a;
      logic [15:0] w;
      int sel = int'($urandom_range(0, 9));
      a = (sel < 6) ? 4'($urandom_range(0, NUM_REGS-1)) :
          (sel < 8) ? 4'd15 : 4'($urandom_range(NUM_REGS, 14));
      w = {a, 12'($urandom)};
      drive(($urandom_range(0, 3) != 0), w, 4'($urandom), ($urandom_range(0, 49) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
